// File: rtl/device_bus_router_pkg.sv
// Shared widths, register offsets, enums and address helpers for the device bus router.
package device_bus_pkg;

  localparam int ID_W   = 8;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 8;
  localparam int IDX_W  = 4;

  // Upper address nibble that marks control space (0x0ddx).
  localparam logic [3:0] CTRL_NIBBLE = 4'h0;

  // Router register offsets, selected by short_address[1:0].
  localparam logic [1:0] REG_ROUTER_ID = 2'd0;
  localparam logic [1:0] REG_ERR_COUNT = 2'd1;
  localparam logic [1:0] REG_ERR_ADDR  = 2'd2;
  localparam logic [1:0] REG_STATUS    = 2'd3;

  // Read data returned after an aborted (timed-out) access.
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 16'hFFFF;

  // Source latched on each completing cycle; it selects the next cycle's read data.
  typedef enum logic [2:0] {
    SRC_NONE     = 3'd0,
    SRC_CHAN     = 3'd1,
    SRC_ROUTER   = 3'd2,
    SRC_UNMAPPED = 3'd3,
    SRC_TIMEOUT  = 3'd4
  } src_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Device ID from address bits [15:4]: control space uses [11:4], memory space [15:8].
  function automatic logic [ID_W-1:0] extract_id(input logic [11:0] addr_hi);
    logic [ID_W-1:0] id;
    if (addr_hi[11:8] == CTRL_NIBBLE) begin
      id = addr_hi[7:0];
    end else begin
      id = addr_hi[11:4];
    end
    return id;
  endfunction

endpackage

// File: rtl/device_bus_router_decode.sv
// Address decoder: device ID extraction plus lowest-index priority match.
module device_bus_decode
  import device_bus_pkg::*;
#(
  parameter int unsigned                DEVICE_COUNT = 4,
  parameter logic [DEVICE_COUNT*ID_W-1:0] DEVICE_IDS = {8'h40, 8'h10, 8'h04, 8'h02},
  parameter logic [ID_W-1:0]            ROUTER_ID    = 8'hFE
) (
  input  logic [11:0]      address_hi,
  output logic [IDX_W-1:0] match_idx,
  output logic             hit,
  output logic             router_hit
);

  logic [ID_W-1:0] dev_id_s;

  assign dev_id_s = extract_id(address_hi);

  // Scan from the highest channel down so the lowest matching index is written last.
  always_comb begin
    match_idx  = '0;
    hit        = 1'b0;
    for (int i = int'(DEVICE_COUNT) - 1; i >= 0; i--) begin
      match_idx = (DEVICE_IDS[i*ID_W +: ID_W] == dev_id_s) ? IDX_W'(i) : match_idx;
      hit       = hit | (DEVICE_IDS[i*ID_W +: ID_W] == dev_id_s);
    end
    router_hit = (dev_id_s == ROUTER_ID);
  end

endmodule

// File: rtl/device_bus_router.sv
// Device bus router: address decode, per-device wait-state handshake with timeout,
// registered read-data select and a small error/status register file at ROUTER_ID.
module device_bus_router
  import device_bus_pkg::*;
#(
  parameter int unsigned                  DEVICE_COUNT   = 4,
  parameter logic [DEVICE_COUNT*ID_W-1:0] DEVICE_IDS     = {8'h40, 8'h10, 8'h04, 8'h02},
  parameter logic [ID_W-1:0]              ROUTER_ID      = 8'hFE,
  parameter int unsigned                  TIMEOUT_CYCLES = 16
) (
  input  logic                           cpu_clock,
  input  logic                           reset,
  input  logic                           cpu_access,
  input  logic                           cpu_write_en,
  input  logic [ADDR_W-1:0]              cpu_address,
  input  logic [DATA_W-1:0]              cpu_data_out,
  output logic [DATA_W-1:0]              cpu_data_in,
  output logic                           cpu_stall,
  output logic [DEVICE_COUNT-1:0]        dev_select,
  output logic [DEVICE_COUNT-1:0]        dev_write_en,
  output logic                           dev_is_control,
  output logic [7:0]                     dev_short_address,
  output logic [DATA_W-1:0]              dev_data_out,
  input  logic [DEVICE_COUNT*DATA_W-1:0] dev_data_in,
  input  logic [DEVICE_COUNT-1:0]        dev_ready
);

  logic [IDX_W-1:0]        match_idx_s;
  logic                    hit_s;
  logic                    router_hit_s;
  logic                    chan_hit_s;
  logic [DEVICE_COUNT-1:0] chan_onehot_s;
  logic                    ready_s;
  logic                    select_en_s;
  logic                    rtr_write_s;
  logic                    err_unmapped_s;
  logic                    err_timeout_s;
  logic                    err_event_s;
  logic                    clr_count_s;
  logic [1:0]              sticky_clr_s;
  logic [DATA_W-1:0]       reg_rdata_s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  src_e              src_q, src_d;
  logic [IDX_W-1:0]  src_idx_q, src_idx_d;
  logic [DATA_W-1:0] rtr_data_q, rtr_data_d;
  logic [DATA_W-1:0] err_count_q, err_count_d;
  logic [DATA_W-1:0] err_addr_q, err_addr_d;
  logic [1:0]        sticky_q, sticky_d;

  device_bus_decode #(
    .DEVICE_COUNT (DEVICE_COUNT),
    .DEVICE_IDS   (DEVICE_IDS),
    .ROUTER_ID    (ROUTER_ID)
  ) u_decode (
    .address_hi (cpu_address[15:4]),
    .match_idx  (match_idx_s),
    .hit        (hit_s),
    .router_hit (router_hit_s)
  );

  // The router's own ID takes precedence over any channel with the same ID.
  assign chan_hit_s = hit_s & ~router_hit_s;

  // One-hot form of the matched channel, empty when no channel is addressed.
  always_comb begin
    chan_onehot_s = '0;
    for (int i = 0; i < int'(DEVICE_COUNT); i++) begin
      chan_onehot_s[i] = chan_hit_s && (match_idx_s == IDX_W'(i));
    end
  end

  assign ready_s           = |(chan_onehot_s & dev_ready);
  assign dev_select        = select_en_s ? chan_onehot_s : '0;
  assign dev_write_en      = dev_select & {DEVICE_COUNT{cpu_write_en}};
  assign dev_is_control    = (cpu_address[15:12] == CTRL_NIBBLE);
  assign dev_short_address = cpu_address[7:0];
  assign dev_data_out      = cpu_data_out;

  // Handshake FSM next state, stall/strobe enables and the completion source.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    src_d          = SRC_NONE;
    src_idx_d      = '0;
    rtr_data_d     = rtr_data_q;
    cpu_stall      = 1'b0;
    select_en_s    = 1'b0;
    rtr_write_s    = 1'b0;
    err_unmapped_s = 1'b0;
    err_timeout_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_access && chan_hit_s) begin
          select_en_s = 1'b1;
          if (ready_s) begin
            src_d     = SRC_CHAN;
            src_idx_d = match_idx_s;
          end else begin
            state_d    = ST_WAIT;
            wait_cnt_d = 8'd1;
            cpu_stall  = 1'b1;
          end
        end else if (cpu_access && router_hit_s) begin
          src_d       = SRC_ROUTER;
          rtr_data_d  = reg_rdata_s;
          rtr_write_s = cpu_write_en;
        end else if (cpu_access) begin
          src_d          = SRC_UNMAPPED;
          err_unmapped_s = 1'b1;
        end else begin
          src_d = SRC_NONE;
        end
      end
      ST_WAIT: begin
        if (cpu_access && chan_hit_s) begin
          if (ready_s) begin
            select_en_s = 1'b1;
            src_d       = SRC_CHAN;
            src_idx_d   = match_idx_s;
            state_d     = ST_IDLE;
            wait_cnt_d  = 8'd0;
          end else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
            // Abort: strobes and stall drop on this cycle.
            src_d         = SRC_TIMEOUT;
            err_timeout_s = 1'b1;
            state_d       = ST_IDLE;
            wait_cnt_d    = 8'd0;
          end else begin
            select_en_s = 1'b1;
            cpu_stall   = 1'b1;
            wait_cnt_d  = wait_cnt_q + 8'd1;
          end
        end else begin
          // Access withdrawn while waiting: give up quietly.
          state_d    = ST_IDLE;
          wait_cnt_d = 8'd0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // Router register read mux, addressed by the low two address bits.
  always_comb begin
    case (cpu_address[1:0])
      REG_ROUTER_ID: reg_rdata_s = {8'h00, ROUTER_ID};
      REG_ERR_COUNT: reg_rdata_s = err_count_q;
      REG_ERR_ADDR:  reg_rdata_s = err_addr_q;
      REG_STATUS:    reg_rdata_s = {14'h0000, sticky_q};
      default:       reg_rdata_s = 16'h0000;
    endcase
  end

  // Error logging; an error event beats a CPU clear landing on the same cycle.
  always_comb begin
    err_event_s = err_unmapped_s | err_timeout_s;
    clr_count_s = rtr_write_s && (cpu_address[1:0] == REG_ERR_COUNT);
    if (rtr_write_s && (cpu_address[1:0] == REG_STATUS)) begin
      sticky_clr_s = cpu_data_out[1:0];
    end else begin
      sticky_clr_s = 2'b00;
    end
    if (err_event_s) begin
      if (clr_count_s) begin
        err_count_d = 16'h0001;
      end else if (err_count_q == 16'hFFFF) begin
        err_count_d = 16'hFFFF;
      end else begin
        err_count_d = err_count_q + 16'h0001;
      end
      err_addr_d = cpu_address;
    end else begin
      if (clr_count_s) begin
        err_count_d = 16'h0000;
      end else begin
        err_count_d = err_count_q;
      end
      err_addr_d = err_addr_q;
    end
    sticky_d = (sticky_q & ~sticky_clr_s) | {err_timeout_s, err_unmapped_s};
  end

  // Read data for the CPU, chosen by the source latched on the previous cycle.
  always_comb begin
    cpu_data_in = 16'h0000;
    case (src_q)
      SRC_CHAN: begin
        for (int i = 0; i < int'(DEVICE_COUNT); i++) begin
          cpu_data_in = (src_idx_q == IDX_W'(i)) ? dev_data_in[i*DATA_W +: DATA_W] : cpu_data_in;
        end
      end
      SRC_ROUTER:  cpu_data_in = rtr_data_q;
      SRC_TIMEOUT: cpu_data_in = TIMEOUT_DATA;
      default:     cpu_data_in = 16'h0000;
    endcase
  end

  // State, completion latch and router registers.
  always_ff @(posedge cpu_clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= 8'd0;
      src_q       <= SRC_NONE;
      src_idx_q   <= 4'd0;
      rtr_data_q  <= 16'h0000;
      err_count_q <= 16'h0000;
      err_addr_q  <= 16'h0000;
      sticky_q    <= 2'b00;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      src_q       <= src_d;
      src_idx_q   <= src_idx_d;
      rtr_data_q  <= rtr_data_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
      sticky_q    <= sticky_d;
    end
  end

endmodule
